// File: rtl/lcd_nibble_reader.sv
// rtl/lcd_nibble_reader.sv - HD44780 4-bit bus reader: one byte per request as two nibble reads
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   req_valid/req_rs/req_ready   read request (req_rs: 0 = busy/address, 1 = data)
//   rsp_valid/rsp_ready      response handshake, rsp_data = {high, low} nibble
//   rsp_busy                 busy flag (rsp_data[7]) for RS=0 reads, else 0
//   lcd_db_in                LCD DB[7:4] sampled from the pins
//   lcd_e/lcd_rs/lcd_rw      LCD control pins
//   bus_own                  block owns the LCD pins; top level must tristate DB drivers
//   sf_ce0                   StrataFlash disable, tied high
module lcd_nibble_reader #(
  parameter int SETUP_CYC = 2,
  parameter int EHIGH_CYC = 12,
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  output logic       req_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  input  logic [3:0] lcd_db_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       bus_own,
  output logic       sf_ce0
);

  typedef enum logic [3:0] {
    IDLE, SETUP_H, EHIGH_H, HOLD_H, GAP_H,
    SETUP_L, EHIGH_L, HOLD_L, GAP_L, RESP
  } state_t;

  // Counter load values: a state lasting N clocks counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EHIGH_LD = 8'(EHIGH_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       armed;       // low during reset and for the first cycle after it
  logic       latched_rs;
  logic [7:0] data_q;

  function automatic logic [7:0] load_for(input state_t s);
    case (s)
      SETUP_H, SETUP_L: return SETUP_LD;
      EHIGH_H, EHIGH_L: return EHIGH_LD;
      HOLD_H,  HOLD_L:  return HOLD_LD;
      GAP_H,   GAP_L:   return GAP_LD;
      default:          return 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:    if (req_valid && armed) state_d = SETUP_H;
      SETUP_H: if (cnt == 8'd0) state_d = EHIGH_H;
      EHIGH_H: if (cnt == 8'd0) state_d = HOLD_H;
      HOLD_H:  if (cnt == 8'd0) state_d = GAP_H;
      GAP_H:   if (cnt == 8'd0) state_d = SETUP_L;
      SETUP_L: if (cnt == 8'd0) state_d = EHIGH_L;
      EHIGH_L: if (cnt == 8'd0) state_d = HOLD_L;
      HOLD_L:  if (cnt == 8'd0) state_d = GAP_L;
      GAP_L:   if (cnt == 8'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state) begin
      cnt_d = load_for(state_d);
    end else if (cnt != 8'd0) begin
      cnt_d = cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      armed      <= 1'b0;
      latched_rs <= 1'b0;
      data_q     <= 8'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      armed <= 1'b1;
      if (state == IDLE && state_d == SETUP_H) latched_rs <= req_rs;
      // Sample on the edge that ends the last E-high clock, E still high.
      if (state == EHIGH_H && cnt == 8'd0) data_q[7:4] <= lcd_db_in;
      if (state == EHIGH_L && cnt == 8'd0) data_q[3:0] <= lcd_db_in;
    end
  end

  // Outputs are decoded from registered state only, so they change on clock edges.
  logic in_read;
  assign in_read   = (state != IDLE) && (state != RESP);
  assign bus_own   = in_read;
  assign lcd_rw    = in_read;
  assign lcd_rs    = in_read && latched_rs;
  assign lcd_e     = (state == EHIGH_H) || (state == EHIGH_L);
  assign req_ready = (state == IDLE) && armed;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = data_q;
  assign rsp_busy  = (state == RESP) && !latched_rs && data_q[7];
  assign sf_ce0    = 1'b1;

endmodule
